// File: rtl/test_pattern_gen.sv
// Mode-selectable LED test pattern source: steps a pixel index on divided position_sync pulses
// and renders caterpillar/fill/checker/all-on words. Define PATTERN_SKEW_EN for a per-channel diagonal offset.
module test_pattern_gen #(
    parameter int NB_CHANNELS = 30,
    parameter int PIXELS      = 48,
    parameter int DIV_W       = 16,
    parameter int IDX_W       = $clog2(PIXELS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               restart,
    input  logic               position_sync,
    input  logic [DIV_W-1:0]   step_div,
    input  logic               direction,
    input  logic [1:0]         mode,
    output logic [PIXELS-1:0]  data_out [NB_CHANNELS],
    output logic [IDX_W-1:0]   pixel_index,
    output logic               step_pulse
);

`ifdef PATTERN_SKEW_EN
    localparam bit SKEW_ON = 1'b1;
`else
    localparam bit SKEW_ON = 1'b0;
`endif

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PIXELS - 1);

    logic [DIV_W-1:0]  cnt_r;
    logic [IDX_W-1:0]  idx_r;
    logic              adv_r;
    logic [IDX_W-1:0]  next_idx_s;
    logic [PIXELS-1:0] pattern_s [NB_CHANNELS];

    function automatic logic odd_sum(input int a, input int b, input int c);
        return ((a + b + c) % 2) == 1;
    endfunction

    // Channel offsets are constants once c is fixed by the unrolled loop, so only a compare/subtract remains.
    function automatic int eff_index(input logic [IDX_W-1:0] idx, input int c);
        int e;
        e = int'(idx);
        if (SKEW_ON) begin
            e = e + (c % PIXELS);
            if (e >= PIXELS) begin
                e = e - PIXELS;
            end
        end
        return e;
    endfunction

    function automatic logic [PIXELS-1:0] render(input logic [1:0] m, input int c, input int e);
        logic [PIXELS-1:0] w;
        w = '0;
        for (int j = 0; j < PIXELS; j++) begin
            case (m)
                2'd0:    w[j] = (j == e);
                2'd1:    w[j] = (j <= e);
                2'd2:    w[j] = odd_sum(j, c, e);
                2'd3:    w[j] = 1'b1;
                default: w[j] = 1'b0;
            endcase
        end
        return w;
    endfunction

    // Index after one advance in the currently selected direction.
    always_comb begin
        next_idx_s = idx_r;
        if (direction) begin
            next_idx_s = (idx_r == '0) ? IDX_LAST : idx_r - IDX_W'(1);
        end else begin
            next_idx_s = (idx_r == IDX_LAST) ? '0 : idx_r + IDX_W'(1);
        end
    end

    // Pattern for every channel from the current index and mode.
    always_comb begin
        pattern_s = '{default: '0};
        for (int c = 0; c < NB_CHANNELS; c++) begin
            pattern_s[c] = render(mode, c, eff_index(idx_r, c));
        end
    end

    // Sync counter, index stepping and registered pattern outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r      <= '0;
            idx_r      <= '0;
            adv_r      <= 1'b0;
            step_pulse <= 1'b0;
            data_out   <= '{default: '0};
        end else begin
            data_out   <= pattern_s;
            step_pulse <= adv_r;
            if (restart) begin
                cnt_r <= '0;
                idx_r <= '0;
                adv_r <= 1'b0;
            end else if (enable && position_sync) begin
                if (cnt_r == step_div) begin
                    cnt_r <= '0;
                    idx_r <= next_idx_s;
                    adv_r <= 1'b1;
                end else begin
                    cnt_r <= cnt_r + DIV_W'(1);
                    adv_r <= 1'b0;
                end
            end else begin
                adv_r <= 1'b0;
            end
        end
    end

    assign pixel_index = idx_r;

endmodule

// File: doc/test_pattern_gen.md
# test_pattern_gen

Parametrised, mode-selectable test pattern source for the LED driver chain. It replaces hard-wired single-pattern test logic in top-level test builds. It counts `position_sync` pulses and advances a pixel index every `step_div`+1 pulses, then renders one of four patterns into a registered per-channel data bus. The output bus feeds the `data_in` port of the driver controller directly, and the block is used for bring-up and caterpillar/fill/checker visual tests.

## Interface
- `NB_CHANNELS`, 30: number of driver serial channels (one `data_out` word each).
- `PIXELS`, 48: bits per channel word; the index range is 0..PIXELS-1. Must be ≥2.
- `DIV_W`, 16: width of `step_div` and of the internal sync counter.
- `IDX_W`, $clog2(PIXELS): width of the pixel index.

- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  when low, the sync counter and the index hold.
- `restart`  in  1  synchronous clear of the index and the sync counter; priority over `position_sync`.
- `position_sync`  in  1  single-cycle pulse, one per column position.
- `step_div`  in  DIV_W  pulses per step minus one; 0 means step on every pulse.
- `direction`  in  1  0 = index increments, 1 = index decrements.
- `mode`  in  2  0 caterpillar, 1 fill bar, 2 checker, 3 all-on.
- `data_out`  out  [NB_CHANNELS][PIXELS]  registered pattern, unpacked array of channel words.
- `pixel_index`  out  IDX_W  current index (register, not delayed).
- `step_pulse`  out  1  high for one cycle, aligned with the first `data_out` showing a new index.

## Operation
- Sync counter `cnt` (DIV_W bits), index `idx` (IDX_W bits).
- Priority each cycle: `rst` > `restart` > (`enable` && `position_sync`) > hold.
  - `restart`: `cnt`←0, `idx`←0. An advance requested in the same cycle is dropped.
  - Counted pulse with `cnt == step_div`: `cnt`←0, and `idx` advances.
  - Counted pulse with `cnt != step_div`: `cnt`←`cnt`+1.
  - If `step_div` is lowered below the current `cnt`, the counter continues to wrap at 2^DIV_W; no early match is forced.
- Advance rules:
  - Forward: `idx` PIXELS-1 → 0, otherwise +1.
  - Reverse: `idx` 0 → PIXELS-1, otherwise -1.
  - `direction` changes take effect at the next advance.
- Effective index for channel c is e(c) = `idx` (see Configuration).
- Pattern for bit j of channel c:
  - mode 0: j == e(c).
  - mode 1: j ≤ e(c).
  - mode 2: (j + c + e(c)) is odd.
  - mode 3: 1.
- `mode` is combinational into the output register. A mode change appears one cycle later and never disturbs `idx` or `cnt`.
- `enable` low freezes the index only. `data_out` keeps tracking `mode`.

## Timing
- Reset values:
  - `data_out` all zero.
  - `step_pulse` 0.
  - `pixel_index` 0.
  - `cnt` 0.
- First post-reset edge loads `data_out` with the pattern for index 0.
- A pulse sampled at edge k that completes a step updates `idx`/`pixel_index` at edge k. The new `data_out` and `step_pulse`=1 follow at edge k+1, so latency is 1 cycle from index to data.
- `restart` at edge k: `pixel_index`=0 after edge k, `data_out` for index 0 after edge k+1. `step_pulse` is not asserted.
- Back-to-back pulses with `step_div`=0 advance the index every cycle, and `step_pulse` stays high continuously.
- `rst` mid-run clears everything at that edge, regardless of other inputs.

## Configuration
- `PATTERN_SKEW_EN` defined:
  - e(c) = (`idx` + (c mod PIXELS)) mod PIXELS. Forward/reverse wrap applies per channel, producing a diagonal sweep across channels.
  - Offsets are elaboration-time constants, so no runtime multiplier or divider is needed.
- Undefined: e(c) = `idx` for every channel, and all channels are identical.

## Test plan
- Reset, mode 0, step_div=256, 257 pulses → `pixel_index` 0→1 on the 257th pulse; `data_out[c]` = 1<<1 one cycle later; `step_pulse` is a single cycle.
- step_div=0, direction=1, 3 back-to-back pulses from idx 0 → indices 47, 46, 45; `data_out[0]` bit 47, then 46, then 45.
- Mode 1 at idx 5 → each word = 0x3F; switch to mode 3 → all-ones the next cycle, `idx` unchanged.
- `restart` and a completing `position_sync` in the same cycle at idx 10 → `pixel_index`=0, `cnt`=0, no `step_pulse`.
- `enable`=0 during 1000 pulses → `idx`/`cnt` unchanged; mode 2 at idx 0 gives `data_out[0]`=0xAAAA_AAAA_AAAA (48 bits), `data_out[1]`=0x5555_5555_5555.
- With `PATTERN_SKEW_EN`, mode 0, idx 47 → `data_out[0]` bit 47, `data_out[1]` bit 0, `data_out[29]` bit 28.
